// File: rtl/bicubic_out_pkg.sv
// Shared types for the Bicubic AXI4-Stream output buffer.
// A FIFO entry carries one re-aligned two-pixel word plus its frame/line markers.
package bicubic_out_pkg;

    localparam int PIXEL_WORD_W = 32;

    typedef struct packed {
        logic                    last;
        logic                    user;
        logic [PIXEL_WORD_W-1:0] data;
    } out_word_t;

endpackage

// File: rtl/bicubic_out_fifo.sv
// First-word-fall-through FIFO for the output buffer.
// The head entry is always visible on dout; dout reads as zero while empty.
module bicubic_out_fifo
    import bicubic_out_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   sclr,
    input  logic                   push,
    input  logic                   pop,
    input  out_word_t              din,
    output out_word_t              dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    out_word_t   mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] count_r;
    logic        wr_en_s;
    logic        rd_en_s;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign wr_en_s = push && !full && !sclr;
    assign rd_en_s = pop && !empty && !sclr;
    assign dout    = empty ? out_word_t'('0) : mem_r[rd_ptr_r[AW-1:0]];
    assign count   = count_r;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (sclr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + PTR_ONE;
                2'b01:   count_r <= count_r - PTR_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bicubic_axis_out_buffer.sv
// AXI4-Stream video master behind the Bicubic re-align stage: a one-word lookahead
// stage resolves late EOL markers, a FIFO absorbs back-pressure, and pipe_clken stalls upstream.
module bicubic_axis_out_buffer
    import bicubic_out_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int SLACK = 8
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    sclr,
    input  logic [PIXEL_WORD_W-1:0] pixel_in,
    input  logic                    pixel_valid_in,
    input  logic                    pixel_start_of_frame_in,
    input  logic                    pixel_end_of_line_in,
    output logic                    pipe_clken,
    output logic [PIXEL_WORD_W-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_LIMIT = (AW+1)'(DEPTH - SLACK);

    logic [PIXEL_WORD_W-1:0] stg_data_r;
    logic                    stg_sof_r;
    logic                    stg_last_r;
    logic                    stg_full_r;
    logic                    overflow_r;

    logic                    push_s;
    logic                    load_s;
    logic                    clear_s;
    out_word_t               push_word_s;
    out_word_t               head_s;
    logic                    fifo_empty_s;
    logic                    fifo_full_s;
    logic [AW:0]             fifo_count_s;

    // Upstream keeps running only while enough free slots remain for words in flight.
    assign pipe_clken    = (fifo_count_s <= CNT_LIMIT);
    assign m_axis_tvalid = !fifo_empty_s;
    assign m_axis_tdata  = head_s.data;
    assign m_axis_tuser  = head_s.user;
    assign m_axis_tlast  = head_s.last;
    assign overflow      = overflow_r;

    // Lookahead decision: the staged word is released once the next event tells us its last flag.
    always_comb begin
        push_s      = 1'b0;
        load_s      = 1'b0;
        clear_s     = 1'b0;
        push_word_s = '{last: stg_last_r, user: stg_sof_r, data: stg_data_r};
        if (pipe_clken) begin
            case ({pixel_valid_in, pixel_end_of_line_in})
                2'b10, 2'b11: begin
                    push_s = stg_full_r;
                    load_s = 1'b1;
                end
                2'b01: begin
                    push_s           = stg_full_r;
                    clear_s          = stg_full_r;
                    push_word_s.last = 1'b1;
                end
                default: begin
                    push_s  = stg_full_r && stg_last_r;
                    clear_s = stg_full_r && stg_last_r;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Lookahead stage register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stg_data_r <= '0;
            stg_sof_r  <= 1'b0;
            stg_last_r <= 1'b0;
            stg_full_r <= 1'b0;
        end else if (sclr) begin
            stg_data_r <= '0;
            stg_sof_r  <= 1'b0;
            stg_last_r <= 1'b0;
            stg_full_r <= 1'b0;
        end else if (load_s) begin
            stg_data_r <= pixel_in;
            stg_sof_r  <= pixel_start_of_frame_in;
            stg_last_r <= pixel_end_of_line_in;
            stg_full_r <= 1'b1;
        end else if (clear_s) begin
            stg_full_r <= 1'b0;
        end
    end

    // Sticky record of any word dropped against a full FIFO.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_r <= 1'b0;
        end else if (sclr) begin
            overflow_r <= 1'b0;
        end else if (push_s && fifo_full_s) begin
            overflow_r <= 1'b1;
        end
    end

    bicubic_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .sclr    (sclr),
        .push    (push_s),
        .pop     (m_axis_tvalid && m_axis_tready),
        .din     (push_word_s),
        .dout    (head_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .count   (fifo_count_s)
    );

endmodule

// File: doc/bicubic_axis_out_buffer.md
# bicubic_axis_out_buffer

Output buffer stage directly downstream of the Bicubic pixel re-align stage. It turns the re-aligned two-pixel word stream (valid / start-of-frame / end-of-line flags) into an AXI4-Stream video master with `tuser` = SOF and `tlast` = EOL. It absorbs downstream back-pressure in a FIFO. It drives the clock-enable of the whole upstream Bicubic pipeline so the pipeline stalls before the FIFO can overflow.

## Interface
- `DEPTH`, 64: FIFO depth in words; power of two, at least 16.
- `SLACK`, 8: free FIFO slots required to keep the pipeline enabled; covers pipeline words in flight.
- `clk` in 1: the only clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `sclr` in 1: synchronous clear. Flushes the FIFO and the stage register, and clears the sticky error.
- `pixel_in` in 32: re-aligned word, `{pixel1[15:0], pixel0[15:0]}`.
- `pixel_valid_in` in 1: the word is valid.
- `pixel_start_of_frame_in` in 1: the word is the first of a frame. Meaningful only with valid.
- `pixel_end_of_line_in` in 1: end-of-line marker. May arrive with or without valid.
- `pipe_clken` out 1: clock-enable for the upstream pipeline.
- `m_axis_tdata` out 32: output word.
- `m_axis_tvalid` out 1: AXI4-Stream valid.
- `m_axis_tready` in 1: AXI4-Stream ready.
- `m_axis_tuser` out 1: start of frame.
- `m_axis_tlast` out 1: end of line.
- `overflow` out 1: sticky. Set when a push finds the FIFO full.

## Operation
- Input qualification: the inputs are sampled only in cycles where `pipe_clken` = 1. Upstream registers hold their values while the enable is low, so sampling in other cycles would duplicate words.
- One-word lookahead stage register `stg` holds `{data, sof, pend_last}` plus a `stg_full` flag. It is needed because EOL can arrive on a cycle after the last valid word. The rules below are evaluated in one qualified cycle, and at most one FIFO push happens per cycle.
  - valid=1, eol=0: if `stg_full`, push `stg` with last = `pend_last`. Then load the incoming word with `pend_last` = 0.
  - valid=0, eol=1: if `stg_full`, push `stg` with last = 1 and clear `stg_full`. If `stg` is empty, ignore the EOL.
  - valid=1, eol=1: if `stg_full`, push `stg` with last = `pend_last`. Then load the incoming word with `pend_last` = 1.
  - valid=0, eol=0, `stg_full` and `pend_last` = 1: push `stg` with last = 1 and clear `stg_full`.
  - Any other case: no action.
- FIFO word is `{last, user, data}`, 34 bits wide. It is first-word-fall-through: `m_axis_*` come from the head entry and `m_axis_tvalid` = not empty.
- A pop happens when `tvalid && tready`. Push and pop in the same cycle leave the count unchanged.
- `pipe_clken` = (`DEPTH` − count ≥ `SLACK`). It is combinational from the registered count.
- Overflow: a push into a full FIFO is dropped and sets `overflow`. Only `sclr` or reset clears it.
- `sclr` is synchronous and not gated by clken. It sets count to 0, pointers to 0, `stg_full` to 0 and `overflow` to 0. Any push or pop in the same cycle is ignored.

## Timing
- Values during reset and after `sclr`:
  - `m_axis_tvalid`, `m_axis_tuser`, `m_axis_tlast`, `overflow` = 0.
  - `m_axis_tdata` = 0.
  - `pipe_clken` = 1 (FIFO empty).
- Latency: an input word appears on `m_axis_tdata` at least 2 cycles after it is sampled. That is one cycle in `stg` plus one cycle of FIFO write, and only if the FIFO was empty.
- AXI rule: once `tvalid` is asserted, tdata, tuser and tlast stay stable until the handshake.
- `pipe_clken` falls in the same cycle the count reaches `DEPTH` − `SLACK` + 1. It rises in the cycle after the pop that frees the slot.
- Wrap-around: pointers are `$clog2(DEPTH)` bits plus one extra bit. Full = MSBs differ and the remaining bits are equal.

## Structure
- Package `bicubic_out_pkg` holds:
  - typedef `out_word_t` (packed struct: `last`, `user`, `data[31:0]`);
  - the constant `PIXEL_WORD_W` = 32.
- Sub-module `bicubic_out_fifo`: synchronous FWFT FIFO with parameter `DEPTH`, ports `sclr`, `push`, `pop`, `din`, `dout`, `empty`, `full`, `count`.
- The top level holds the stage logic, the clken generation and the overflow flag.

## Test plan
- Basic line: reset, `tready` = 1. Send words 0x00010000..0x00040003 with SOF on the first word, then EOL alone one cycle later.
  - Expected: 4 beats, tuser = 1 only on beat 0, tlast = 1 only on beat 3.
- EOL coincident with valid: send the last word 0xAAAA5555 with valid = 1 and eol = 1, then idle.
  - Expected: that word is output with tlast = 1, one cycle after the previous word is pushed.
- Back-pressure: `DEPTH` = 16, `SLACK` = 4, `tready` = 0, continuous valid input.
  - Expected: `pipe_clken` drops when count reaches 13 and no more pushes occur.
  - Then `tready` = 1: all 13 words drain in order, `overflow` stays 0.
- Forced overflow: drive `pipe_clken` high from the bench (disable the connection) and push 17 words into `DEPTH` = 16.
  - Expected: `overflow` = 1 and stays set. The 17th word is absent from the output.
- `sclr` mid-line: send 5 words, assert `sclr` for one cycle while `tvalid` = 1.
  - Expected: next cycle `tvalid` = 0, `overflow` = 0, `pipe_clken` = 1. A following frame outputs cleanly.
- Async reset mid-stream: pulse `aresetn` low between clock edges.
  - Expected: outputs go to their reset values immediately. No stale beat appears after release.
